// File: rtl/mnpk_isa_pkg.sv
// rtl/mnpk_isa_pkg.sv - mnpk01 opcode constants and execute-sequencer state encoding
package mnpk_isa_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_LDW  = 8'h03;
  localparam logic [7:0] OP_ADDW = 8'h04;
  localparam logic [7:0] OP_ST   = 8'h05;

  typedef enum logic [3:0] {
    S_OPC,
    S_REG,
    S_REG2,
    S_DAT,
    S_DAT2,
    S_EXEC,
    S_WB,
    S_WB2,
    S_MEM
  } state_t;

  // Opcodes are dense from NOP up to ST; anything above is undefined
  function automatic logic is_legal(input logic [7:0] op);
    return (op <= OP_ST);
  endfunction

endpackage

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - mnpk01 execute sequencer: operand assembly, RF and data-memory sequencing
module exec_sequencer
  import mnpk_isa_pkg::*;
#(
  parameter int  NREGS = 8,
  localparam int RA    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [RA-1:0] rf_raddr_a,
  output logic [RA-1:0] rf_raddr_b,
  input  logic [7:0]    rf_rdata_a,
  input  logic [7:0]    rf_rdata_b,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [7:0]    rf_wdata,
  output logic          mem_req,
  output logic [15:0]   mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  output logic          flag_c,
  output logic          busy,
  output logic          illegal_op
);

  state_t        state, state_d;
  logic [7:0]    opc;
  logic [RA-1:0] reg_r;
  logic [RA-1:0] reg_s;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic [7:0]    sum_hi;
  logic          sum_c;
  logic          xfer;
  logic [RA-1:0] r_inc;
  logic [16:0]   sum17;

  assign in_ready = (state == S_OPC) || (state == S_REG) || (state == S_REG2) ||
                    (state == S_DAT) || (state == S_DAT2);
  assign xfer     = in_valid && in_ready;
  assign r_inc    = reg_r + RA'(1);
  assign sum17    = {1'b0, rf_rdata_b, rf_rdata_a} + {1'b0, hi_q, lo_q};
  assign mem_req  = (state == S_MEM);
  assign mem_addr = {hi_q, lo_q};
  assign busy     = (state != S_OPC);

  // State register; async reset abandons any partial instruction and drops mem_req at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OPC;
    else        state <= state_d;
  end

  // Next state plus RF read/write strobes, all decoded from the current state
  always_comb begin
    state_d    = state;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    case (state)
      S_OPC: begin
        if (xfer) begin
          case (in_data)
            OP_LDI, OP_MOV, OP_LDW, OP_ADDW: state_d = S_REG;
            OP_ST:                           state_d = S_DAT;
            default:                         state_d = S_OPC;
          endcase
        end
      end
      S_REG: begin
        if (xfer) begin
          case (opc)
            OP_MOV:  state_d = S_REG2;
            OP_ST:   state_d = S_EXEC;
            default: state_d = S_DAT;
          endcase
        end
      end
      S_REG2: if (xfer) state_d = S_EXEC;
      S_DAT:  if (xfer) state_d = (opc == OP_LDI) ? S_EXEC : S_DAT2;
      S_DAT2: if (xfer) state_d = (opc == OP_ST) ? S_REG : S_EXEC;
      S_EXEC: begin
        case (opc)
          OP_LDI, OP_LDW: begin
            rf_we    = 1'b1;
            rf_waddr = reg_r;
            rf_wdata = lo_q;
            state_d  = (opc == OP_LDI) ? S_OPC : S_WB2;
          end
          OP_MOV: begin
            rf_raddr_a = reg_s;
            state_d    = S_WB;
          end
          OP_ADDW: begin
            rf_raddr_a = reg_r;
            rf_raddr_b = r_inc;
            state_d    = S_WB;
          end
          default: begin
            rf_raddr_a = reg_r;
            state_d    = S_WB;
          end
        endcase
      end
      S_WB: begin
        case (opc)
          OP_MOV: begin
            rf_we    = 1'b1;
            rf_waddr = reg_r;
            rf_wdata = rf_rdata_a;
            state_d  = S_OPC;
          end
          OP_ADDW: begin
            rf_we    = 1'b1;
            rf_waddr = reg_r;
            rf_wdata = sum17[7:0];
            state_d  = S_WB2;
          end
          default: state_d = S_MEM;
        endcase
      end
      S_WB2: begin
        rf_we    = 1'b1;
        rf_waddr = r_inc;
        rf_wdata = (opc == OP_LDW) ? hi_q : sum_hi;
        state_d  = S_OPC;
      end
      S_MEM: if (mem_ack) state_d = S_OPC;
      default: state_d = S_OPC;
    endcase
  end

  // Operand capture, ADDW high-half/carry hold, store data latch, flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc        <= OP_NOP;
      reg_r      <= '0;
      reg_s      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      sum_hi     <= '0;
      sum_c      <= 1'b0;
      mem_wdata  <= '0;
      flag_c     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= (state == S_OPC) && xfer && !is_legal(in_data);
      case (state)
        S_OPC:  if (xfer) opc <= in_data;
        S_REG:  if (xfer) reg_r <= in_data[RA-1:0];
        S_REG2: if (xfer) reg_s <= in_data[RA-1:0];
        S_DAT:  if (xfer) lo_q <= in_data;
        S_DAT2: if (xfer) hi_q <= in_data;
        S_WB: begin
          if (opc == OP_ADDW) {sum_c, sum_hi} <= sum17[16:8];
          if (opc == OP_ST)   mem_wdata <= rf_rdata_a;
        end
        S_WB2: if (opc == OP_ADDW) flag_c <= sum_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0]  rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        flag_c;
  logic        busy;
  logic        illegal_op;

  exec_sequencer #(.NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .flag_c(flag_c), .busy(busy), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Synchronous register file the sequencer drives
  logic [7:0] rf [8];
  initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
  end

  int n_checks = 0;
  int n_errors = 0;
  int ill_count = 0;
  logic [10:0] exp_wr [$];
  logic [23:0] exp_mem [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every RF write and completed memory write is popped against the expectation queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (illegal_op) ill_count++;
      if (rf_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rf_write_unexpected: got addr %0d data %0h, required no write", rf_waddr, rf_wdata);
        end else chk("rf_write", {rf_waddr, rf_wdata}, exp_wr.pop_front());
      end
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL mem_write_unexpected: got %0h/%0h, required none", mem_addr, mem_wdata);
        end else chk("mem_write", {mem_addr, mem_wdata}, exp_mem.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1; in_data = b; t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL in_ready_timeout: got 0, required 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin @(posedge clk); #1; t++; end
    if (busy) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: busy got 1, required 0 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_mem_req();
    int t = 0;
    while (!mem_req && t < 20) begin @(posedge clk); #1; t++; end
    chk("mem_req_raised", mem_req, 1);
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    int          nw;
    logic [2:0]  wa0;
    logic [7:0]  wd0;
    logic [2:0]  wa1;
    logic [7:0]  wd1;
    logic        c;
    logic        ill;
    logic        gap;
  } vec_t;

  function automatic vec_t mk(logic [31:0] bytes, int nb, int nw, logic [2:0] wa0, logic [7:0] wd0,
                              logic [2:0] wa1, logic [7:0] wd1, logic c, logic ill, logic gap);
    vec_t v;
    v.bytes = bytes; v.nb = nb; v.nw = nw;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.c = c; v.ill = ill; v.gap = gap;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    vecs[0]  = mk(32'h01035A00, 3, 1, 3'd3, 8'h5A, 3'd0, 8'h00, 0, 0, 0);  // LDI r3,5A
    vecs[1]  = mk(32'h03020001, 4, 2, 3'd2, 8'h00, 3'd3, 8'h01, 0, 0, 0);  // LDW r2,0100
    vecs[2]  = mk(32'h040200FF, 4, 2, 3'd2, 8'h00, 3'd3, 8'h00, 1, 0, 0);  // ADDW 0100+FF00
    vecs[3]  = mk(32'h03043412, 4, 2, 3'd4, 8'h34, 3'd5, 8'h12, 1, 0, 0);  // LDW keeps carry
    vecs[4]  = mk(32'h04040100, 4, 2, 3'd4, 8'h35, 3'd5, 8'h12, 0, 0, 0);  // ADDW 1234+0001
    vecs[5]  = mk(32'h00000000, 1, 0, 3'd0, 8'h00, 3'd0, 8'h00, 0, 0, 0);  // NOP
    vecs[6]  = mk(32'h7E000000, 1, 0, 3'd0, 8'h00, 3'd0, 8'h00, 0, 1, 0);  // illegal 7E
    vecs[7]  = mk(32'h00000000, 1, 0, 3'd0, 8'h00, 3'd0, 8'h00, 0, 0, 0);  // NOP after illegal
    vecs[8]  = mk(32'h0101C300, 3, 1, 3'd1, 8'hC3, 3'd0, 8'h00, 0, 0, 0);  // LDI r1,C3
    vecs[9]  = mk(32'h02060100, 3, 1, 3'd6, 8'hC3, 3'd0, 8'h00, 0, 0, 0);  // MOV r6,r1
    vecs[10] = mk(32'h01F91100, 3, 1, 3'd1, 8'h11, 3'd0, 8'h00, 0, 0, 0);  // reg byte F9 -> r1
    vecs[11] = mk(32'h0401FF00, 4, 2, 3'd1, 8'h10, 3'd2, 8'h01, 0, 0, 0);  // ADDW 0011+00FF
    vecs[12] = mk(32'h01035A00, 3, 1, 3'd3, 8'h5A, 3'd0, 8'h00, 0, 0, 1);  // LDI with gaps
    vecs[13] = mk(32'h0401F0FF, 4, 2, 3'd1, 8'h00, 3'd2, 8'h01, 1, 0, 0);  // ADDW 0110+FFF0
    vecs[14] = mk(32'hFF000000, 1, 0, 3'd0, 8'h00, 3'd0, 8'h00, 1, 1, 0);  // illegal FF

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_flag_c", flag_c, 0);
    chk("reset_illegal", illegal_op, 0);
    chk("reset_mem_addr_data", {mem_addr, mem_wdata}, 0);
    chk("reset_rf_addr_data", {rf_waddr, rf_wdata}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      int ill0;
      ill0 = ill_count;
      if (vecs[i].nw > 0) exp_wr.push_back({vecs[i].wa0, vecs[i].wd0});
      if (vecs[i].nw > 1) exp_wr.push_back({vecs[i].wa1, vecs[i].wd1});
      for (int k = 0; k < vecs[i].nb; k++) begin
        logic [31:0] w;
        w = vecs[i].bytes;
        send_byte(w[31-8*k -: 8], vecs[i].gap);
      end
      wait_idle();
      chk($sformatf("vec%0d_writes_pending", i), exp_wr.size(), 0);
      chk($sformatf("vec%0d_flag_c", i), flag_c, vecs[i].c);
      chk($sformatf("vec%0d_illegal_pulses", i), ill_count - ill0, vecs[i].ill);
    end

    // LDI latency: write visible the cycle after the last operand, exactly one pulse
    exp_wr.push_back({3'd3, 8'h5A});
    send_byte(8'h01, 0); send_byte(8'h03, 0); send_byte(8'h5A, 0);
    chk("ldi_latency_write", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd3, 8'h5A});
    @(posedge clk); #1;
    chk("ldi_single_pulse", rf_we, 0);
    wait_idle();

    // ST with a 3-cycle ack stall; the next opcode byte is held by the producer meanwhile
    exp_mem.push_back({16'h1234, 8'h5A});
    send_byte(8'h05, 0); send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h03, 0);
    wait_mem_req();
    in_valid = 1'b1; in_data = 8'h01;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("st_stall%0d", k), {mem_req, in_ready, mem_addr, mem_wdata}, {1'b1, 1'b0, 16'h1234, 8'h5A});
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("st_req_dropped", {mem_req, in_ready}, {1'b0, 1'b1});
    exp_wr.push_back({3'd5, 8'h77});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("st_next_opcode_taken", busy, 1);
    send_byte(8'h05, 0); send_byte(8'h77, 0);
    wait_idle();
    chk("st_mem_pending", exp_mem.size(), 0);
    chk("st_writes_pending", exp_wr.size(), 0);

    // Register index wrap: LDW r7 writes r7 then r0 back to back
    exp_wr.push_back({3'd7, 8'hAA});
    exp_wr.push_back({3'd0, 8'hBB});
    send_byte(8'h03, 0); send_byte(8'h07, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    chk("wrap_first", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd7, 8'hAA});
    @(posedge clk); #1;
    chk("wrap_second", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd0, 8'hBB});
    wait_idle();
    exp_wr.push_back({3'd5, 8'hAA});
    send_byte(8'h02, 0); send_byte(8'h05, 0); send_byte(8'h07, 0);
    wait_idle();
    chk("mov_r5", rf[5], 8'hAA);
    chk("wrap_writes_pending", exp_wr.size(), 0);

    // Reset while a store is outstanding
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h80, 0); send_byte(8'h03, 0);
    wait_mem_req();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_st", {mem_req, busy, rf_we, in_ready, flag_c}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle_after", {mem_req, busy, flag_c}, 0);
    chk("rst_no_pending", exp_wr.size() + exp_mem.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
